hfrv_uart_rx: RTL and testbench

- Serial UART receiver (8N1, LSB first) for the hf-riscv SoC.
- Drives characters into the core's peripheral bus, the counterpart of the core's transmit path that the bench UART monitor captures.
- Samples the line at mid-bit with a runtime divisor and validates the start and stop bits.
- Buffers received bytes in a small show-ahead FIFO with a valid/ready read port; reports framing and overrun errors.

---
 rtl/hfrv_uart_rx.sv | 153 +++++++++++++++
 tb/tb_hfrv_uart_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hfrv_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a runtime divisor, start/stop validation,
// and a show-ahead receive FIFO with framing and overrun reporting.
module hfrv_uart_rx #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic             rxd_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  input  logic             clear_i,
  output logic             busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, div_q, div_n, div_eff;
  logic [2:0]       bitn, bitn_n;
  logic [7:0]       shreg, shreg_n;
  logic             push, ferr_n, ferr_q;
  logic             rx_m, rxs, rxs_d, armed, fall;
  logic [1:0]       warm;

  // armed only after rxs has carried a real high sample, so a line held low
  // across reset release is not mistaken for a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      rx_m  <= rxd_i;
      rxs   <= rx_m;
      rxs_d <= rxs;
      warm  <= {warm[0], 1'b1};
      if (warm[1] && rxs) armed <= 1'b1;
    end
  end

  assign fall    = armed & rxs_d & ~rxs;
  assign div_eff = (div_i < DIV_W'(4)) ? DIV_W'(4) : div_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= '0;
      bitn   <= '0;
      shreg  <= '0;
      ferr_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      div_q  <= div_n;
      bitn   <= bitn_n;
      shreg  <= shreg_n;
      ferr_q <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_q;
    bitn_n  = bitn;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: if (fall) begin
        div_n   = div_eff;
        cnt_n   = (div_eff >> 1) - 1'b1;
        state_n = START;
      end
      START: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (!rxs) begin
          cnt_n   = div_q - 1'b1;
          bitn_n  = '0;
          state_n = DATA;
        end else state_n = IDLE;
      end
      DATA: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          shreg_n = {rxs, shreg[7:1]};
          cnt_n   = div_q - 1'b1;
          bitn_n  = bitn + 1'b1;
          if (bitn == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (rxs) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign frame_err_o = ferr_q;

  // receive FIFO; data_o is a registered copy of the next head
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n, count;
  logic        empty, full, pop, push_ok;
  logic [7:0]  head_n;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = ~empty & ready_i;
  assign push_ok = push & (~full | pop);
  assign rptr_n  = rptr + (AW+1)'(pop);
  assign wptr_n  = wptr + (AW+1)'(push_ok);
  assign head_n  = (push_ok && rptr_n == wptr) ? shreg : mem[rptr_n[AW-1:0]];
  assign valid_o = ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      data_o    <= '0;
      overrun_o <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      if (wptr_n != rptr_n) data_o <= head_n;
      if (push & full & ~pop) overrun_o <= 1'b1;
      else if (clear_i)       overrun_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hfrv_uart_rx.sv
// Self-checking bench for hfrv_uart_rx: directed scenarios plus randomized frames
// checked against a queue model of the receive FIFO.
module tb_hfrv_uart_rx;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [15:0] div_i = 16'd16;
  logic        rxd_i = 1'b1, ready_i = 1'b0, clear_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o, frame_err_o, overrun_o, busy_o;

  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, ferr_cyc = 0, lat = -1;
  int t0, p0, f0;
  bit exp_ovr = 1'b0;
  byte unsigned exp_q[$];

  hfrv_uart_rx #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .div_i(div_i), .rxd_i(rxd_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .clear_i(clear_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // pops are checked in order against the model queue
  always @(negedge clk) begin
    if (frame_err_o) ferr_cyc++;
    if (reset_n && valid_o && ready_i) begin
      pops++;
      if (exp_q.size() == 0) chk("pop_extra", valid_o, 0);
      else chk("pop_data", data_o, exp_q.pop_front());
    end
  end

  // one 8N1 frame; model FIFO holds at most 4 bytes, extra good frames mean overrun
  task automatic send(input byte unsigned b, input int dv, input bit stop_ok, input bit scramble);
    int p;
    p = (dv < 4) ? 4 : dv;
    div_i = 16'(dv);
    rxd_i = 1'b0; tick(p);
    if (scramble) div_i = 16'($urandom_range(4, 40));
    for (int i = 0; i < 8; i++) begin rxd_i = b[i]; tick(p); end
    rxd_i = stop_ok; tick(p);
    if (stop_ok) begin
      if (exp_q.size() < 4) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  initial begin
    tick(3); reset_n = 1'b1; tick(4);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_ovr", overrun_o, 0);
    chk("rst_busy", busy_o, 0);

    // single byte with latency window
    fork
      send(8'h55, 16, 1'b1, 1'b0);
      begin
        t0 = cyc;
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (valid_o) begin lat = cyc - t0; break; end
        end
      end
    join
    chk("lat_window", (lat >= 152 && lat <= 156), 1);
    chk("one_head", data_o, 8'h55);
    p0 = pops; ready_i = 1'b1; tick(1); ready_i = 1'b0;
    chk("one_pop", pops - p0, 1);
    chk("one_empty", valid_o, 0);
    chk("one_noferr", ferr_cyc, 0);

    // three back-to-back bytes, drained one per cycle
    send(8'hA3, 16, 1'b1, 1'b0); send(8'h00, 16, 1'b1, 1'b0); send(8'hFF, 16, 1'b1, 1'b0);
    tick(2);
    chk("b2b_valid", valid_o, 1);
    chk("b2b_head", data_o, 8'hA3);
    p0 = pops; ready_i = 1'b1; tick(3); ready_i = 1'b0;
    chk("b2b_pops", pops - p0, 3);
    chk("b2b_empty", valid_o, 0);

    // framing error, then a long break
    f0 = ferr_cyc;
    send(8'h3C, 16, 1'b0, 1'b0);
    tick(48);
    chk("ferr_once", ferr_cyc - f0, 1);
    chk("ferr_wait_busy", busy_o, 1);
    chk("ferr_nopush", valid_o, 0);
    rxd_i = 1'b1; tick(6);
    chk("ferr_idle", busy_o, 0);
    chk("ferr_still_once", ferr_cyc - f0, 1);

    // 4-clock glitch on idle line
    f0 = ferr_cyc;
    div_i = 16'd16; rxd_i = 1'b0; tick(4); rxd_i = 1'b1;
    chk("glitch_busy", busy_o, 1);
    tick(8);
    chk("glitch_idle", busy_o, 0);
    chk("glitch_nopush", valid_o, 0);
    chk("glitch_noferr", ferr_cyc - f0, 0);

    // overrun with 5 bytes into a 4-deep FIFO
    exp_ovr = 1'b0;
    for (int v = 1; v <= 5; v++) send(8'(v), 16, 1'b1, 1'b0);
    tick(2);
    chk("ovr_set", overrun_o, exp_ovr);
    clear_i = 1'b1; tick(1); clear_i = 1'b0;
    chk("ovr_clear", overrun_o, 0);
    p0 = pops; ready_i = 1'b1; tick(6); ready_i = 1'b0;
    chk("ovr_pops", pops - p0, 4);
    chk("ovr_empty", valid_o, 0);

    // reset in the middle of 0x81, with a byte already buffered
    send(8'h77, 16, 1'b1, 1'b0);
    tick(2);
    div_i = 16'd16; rxd_i = 1'b0; tick(16);
    rxd_i = 1'b1; tick(16);
    rxd_i = 1'b0; tick(16);
    tick(5);
    reset_n = 1'b0; exp_q.delete(); tick(1);
    chk("mrst_data", data_o, 0);
    chk("mrst_valid", valid_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_ferr", frame_err_o, 0);
    tick(2); reset_n = 1'b1; tick(40);
    chk("mrst_lowline_idle", busy_o, 0);
    rxd_i = 1'b1; tick(5);
    send(8'h42, 16, 1'b1, 1'b0);
    tick(2);
    chk("mrst_rx_valid", valid_o, 1);
    p0 = pops; ready_i = 1'b1; tick(1); ready_i = 1'b0;
    chk("mrst_rx_pop", pops - p0, 1);

    // randomized frames, divisors (including <4) and mid-frame divisor changes
    f0 = ferr_cyc;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        send(8'($urandom), $urandom_range(2, 24), 1'b1, 1'($urandom));
        tick($urandom_range(0, 3));
      end
      tick(2);
      chk("rnd_valid", valid_o, 1);
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
        ready_i = 1'($urandom); tick(1);
      end
      ready_i = 1'b0; tick(1);
      chk("rnd_drained", exp_q.size(), 0);
      chk("rnd_empty", valid_o, 0);
    end
    chk("rnd_noferr", ferr_cyc - f0, 0);
    chk("rnd_noovr", overrun_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
